// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and EX-side resolution bundle for branch_predictor.
// The pipeline uses the master modport; the predictor uses the slave modport.
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             flush_i;
    logic [XLEN-1:0]  if_pc_i;
    logic             pred_taken_o;
    logic [XLEN-1:0]  pred_target_o;
    logic             ex_valid_i;
    logic             ex_is_branch_i;
    logic             ex_is_jump_i;
    logic [XLEN-1:0]  ex_pc_i;
    logic             ex_taken_i;
    logic [XLEN-1:0]  ex_target_i;
    logic             ex_pred_taken_i;
    logic [XLEN-1:0]  ex_pred_target_i;
    logic             mispredict_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] branch_count_o;
    logic [CNT_W-1:0] mispredict_count_o;

    modport master (
        output flush_i, if_pc_i,
        output ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_pc_i,
        output ex_taken_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
        input  branch_count_o, mispredict_count_o
    );

    modport slave (
        input  flush_i, if_pc_i,
        input  ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_pc_i,
        input  ex_taken_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
        output branch_count_o, mispredict_count_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, misprediction detection and statistics.
// Latency: lookup and resolution are combinational, BTB/stat updates land on the next edge; no backpressure.
module branch_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic             entry_vld [ENTRIES];
    logic [TAG_W-1:0] entry_tag [ENTRIES];
    logic [XLEN-1:0]  entry_tgt [ENTRIES];
    logic [1:0]       entry_ctr [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             br;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    assign if_idx = bp.if_pc_i[IDX_W+1:2];
    assign if_tag = bp.if_pc_i[IDX_W+1+TAG_W:IDX_W+2];
    assign ex_idx = bp.ex_pc_i[IDX_W+1:2];
    assign ex_tag = bp.ex_pc_i[IDX_W+1+TAG_W:IDX_W+2];

    // Lookup reads pre-edge contents; an EX update to the same entry is not bypassed.
    assign if_hit = entry_vld[if_idx] && (entry_tag[if_idx] == if_tag);
    assign ex_hit = entry_vld[ex_idx] && (entry_tag[ex_idx] == ex_tag);

    assign bp.pred_taken_o  = if_hit & entry_ctr[if_idx][1];
    assign bp.pred_target_o = bp.pred_taken_o ? entry_tgt[if_idx] : bp.if_pc_i + XLEN'(4);

    assign br = bp.ex_valid_i & (bp.ex_is_branch_i | bp.ex_is_jump_i);

    always_comb begin
        mispredict = 1'b0;
        if (br) begin
            mispredict = (bp.ex_pred_taken_i != bp.ex_taken_i) ||
                         (bp.ex_taken_i && (bp.ex_pred_target_i != bp.ex_target_i));
        end else if (bp.ex_valid_i) begin
            // A non-branch predicted taken was a partial-tag alias.
            mispredict = bp.ex_pred_taken_i;
        end
    end

    assign bp.mispredict_o  = mispredict;
    assign bp.redirect_pc_o = (bp.ex_taken_i & br) ? bp.ex_target_i : bp.ex_pc_i + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_vld[i] <= 1'b0;
                entry_tag[i] <= '0;
                entry_tgt[i] <= '0;
                entry_ctr[i] <= CTR_INIT;
            end
        end else if (bp.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_vld[i] <= 1'b0;
                entry_ctr[i] <= CTR_INIT;
            end
        end else if (br) begin
            if (ex_hit) begin
                if (bp.ex_is_jump_i) begin
                    entry_ctr[ex_idx] <= 2'b11;
                    entry_tgt[ex_idx] <= bp.ex_target_i;
                end else if (bp.ex_taken_i) begin
                    if (entry_ctr[ex_idx] != 2'b11)
                        entry_ctr[ex_idx] <= entry_ctr[ex_idx] + 2'd1;
                    entry_tgt[ex_idx] <= bp.ex_target_i;
                end else if (entry_ctr[ex_idx] != 2'b00) begin
                    entry_ctr[ex_idx] <= entry_ctr[ex_idx] - 2'd1;
                end
            end else if (bp.ex_taken_i) begin
                entry_vld[ex_idx] <= 1'b1;
                entry_tag[ex_idx] <= ex_tag;
                entry_tgt[ex_idx] <= bp.ex_target_i;
                entry_ctr[ex_idx] <= bp.ex_is_jump_i ? 2'b11 : 2'b10;
            end
        end else if (bp.ex_valid_i && bp.ex_pred_taken_i && ex_hit) begin
            entry_vld[ex_idx] <= 1'b0;
        end
    end

    // Statistics keep counting through a flush and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (br && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

    assign bp.branch_count_o     = branch_cnt;
    assign bp.mispredict_count_o = mispredict_cnt;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch prediction and resolution unit for the 5-stage RISC-V pipeline; successor to the purely combinational branch comparator.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, looked up combinationally in IF.
- Updated at the clock edge from EX using the resolved outcome, which the existing comparator drives into ex_taken_i.
- Flags mispredictions, supplies the redirect PC and keeps saturating branch/mispredict statistics counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES).
- TAG_W, 8, partial tag bits; requires IDX_W+2+TAG_W <= XLEN.
- CTR_INIT, 2'b01, counter value on reset/flush (weakly not-taken).
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous invalidate-all (fence.i).
- if_pc_i  in  XLEN  fetch PC to predict.
- pred_taken_o  out  1  predicted taken for if_pc_i.
- pred_target_o  out  XLEN  predicted next PC.
- ex_valid_i  in  1  EX holds a valid (non-bubble) instruction.
- ex_is_branch_i  in  1  conditional branch in EX.
- ex_is_jump_i  in  1  JAL in EX; JALR is excluded and is never allocated.
- ex_pc_i  in  XLEN  PC of EX instruction.
- ex_taken_i  in  1  resolved outcome; jumps drive 1.
- ex_target_i  in  XLEN  resolved target.
- ex_pred_taken_i  in  1  prediction carried down from IF.
- ex_pred_target_i  in  XLEN  predicted target carried down from IF.
- mispredict_o  out  1  flush-and-redirect request.
- redirect_pc_o  out  XLEN  correct next PC.
- branch_count_o  out  CNT_W  resolved branches plus jumps.
- mispredict_count_o  out  CNT_W  mispredictions.

Behaviour:
Address fields:
- idx = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W:IDX_W+2].
- Each entry holds valid, tag[TAG_W], target[XLEN], ctr[2].

Reset (rst_n low, asynchronous):
- All valid=0, ctr=CTR_INIT, target=0, both statistics counters=0.
- Outputs are combinational, so after reset pred_taken_o=0, pred_target_o=if_pc_i+4, mispredict_o=0 whenever ex_valid_i=0.

Prediction (combinational, zero latency):
- hit = valid[idx] & (tag[idx]==tag(if_pc_i)).
- pred_taken_o = hit & ctr[idx][1].
- pred_target_o = pred_taken_o ? target[idx] : if_pc_i+4 (mod 2^XLEN).

Resolution (combinational from EX inputs):
- br = ex_valid_i & (ex_is_branch_i | ex_is_jump_i).
- For br: mispredict_o = (ex_pred_taken_i != ex_taken_i) | (ex_taken_i & ex_pred_target_i != ex_target_i).
- For ex_valid_i & ~br: mispredict_o = ex_pred_taken_i. This is a partial-tag alias; redirect to ex_pc_i+4.
- redirect_pc_o = ex_taken_i & br ? ex_target_i : ex_pc_i+4. Its value is don't-care when mispredict_o=0.
- ex_valid_i=0 forces mispredict_o=0 and no update.

Update (registered, entry at idx(ex_pc_i)):
- br & hit, branch: ctr saturating +1 if taken else -1 (11 stays 11, 00 stays 00); target written when taken.
- br & hit, jump: ctr=11, target written.
- br & miss & taken: allocate; valid=1, tag written, target written, ctr = jump ? 11 : 10. This replaces any aliasing occupant.
- br & miss & not taken: no change.
- Alias case (ex_valid_i & ~br & ex_pred_taken_i & hit): entry valid cleared.

Priority and ordering:
- rst_n overrides everything.
- flush_i overrides any same-cycle update: all valid=0, ctr=CTR_INIT.
- Statistics still count on a flush cycle.
- Same-cycle IF lookup and EX update on the same idx: lookup sees pre-edge contents; no bypass.

Statistics:
- branch_count_o +1 per cycle with br.
- mispredict_count_o +1 per cycle with mispredict_o.
- Both saturate at all-ones and never wrap.

Test Plan:
- Reset, if_pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104, both counts 0.
- EX branch pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict_o=1, redirect_pc_o=0x80, branch_count_o=1, mispredict_count_o=1; next cycle if_pc_i=0x100 -> pred_taken_o=1, pred_target_o=0x80.
- Same branch resolved not-taken twice, pred_taken=1 then 0 -> first: mispredict_o=1, redirect_pc_o=0x104 (ctr 10->01); second: mispredict_o=0 (ctr 00); lookup 0x100 -> pred_taken_o=0.
- After allocating 0x100 as taken, lookup 0x140 (same idx 0, tag 5 vs 4) -> miss, pred_target_o=0x144; non-branch in EX at 0x100 with pred_taken=1 -> mispredict_o=1, redirect_pc_o=0x104; entry then invalidated.
- JAL pc=0x200, target 0x300, with flush_i=1 in the same cycle -> branch_count_o increments; lookup 0x200 next cycle -> miss; flush_i alone after a populated BTB -> all lookups miss.
- CNT_W=4: 17 consecutive mispredicted branches -> both counters read 15 and hold. Assert rst_n=0 between clock edges -> counters read 0 immediately.
